// File: rtl/fxp_div_pkg.sv
// fxp_div_pkg: shared types and constants for the fixed-point divider
package fxp_div_pkg;
  localparam int DATA_W = 64;
  localparam int LZ_W = 7;
  localparam int K_W = 8;
  localparam logic [DATA_W-1:0] SAT = '1;
  typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_e;
endpackage

// File: rtl/fxp_div_seq_lzd.sv
// LZD_64bit: leading-zero count of a 64-bit word, 64 when the word is zero
module LZD_64bit
  import fxp_div_pkg::*;
(
  input  logic [DATA_W-1:0] in_data,
  output logic [LZ_W-1:0]   lz
);
  always_comb begin
    lz = LZ_W'(DATA_W);
    for (int i = 0; i < DATA_W; i++) if (in_data[i]) lz = LZ_W'(DATA_W - 1 - i);
  end
endmodule

// File: rtl/fxp_div_seq.sv
// fxp_div_seq: sequential unsigned fixed-point divider, Q = floor(A*2^F/B) saturated
module fxp_div_seq
  import fxp_div_pkg::*;
#(
  parameter int FRAC_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] quotient,
  output logic              overflow,
  output logic              div_by_zero
);
  state_e state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, r_q, r_d, acc_q, acc_d, quo_q, quo_d;
  logic [LZ_W-1:0] cnt_q, cnt_d, lz_n, lz_d, kp1, idx;
  logic ovf_q, ovf_d, dbz_q, dbz_d, ge;
  logic signed [K_W-1:0] k;
  logic [2*DATA_W-2:0] num;
  logic [DATA_W:0] r_sh, acc_nx;
  LZD_64bit u_lzd_n (.in_data(a_q), .lz(lz_n));
  LZD_64bit u_lzd_d (.in_data(b_q), .lz(lz_d));
  assign k = K_W'(FRAC_BITS) + K_W'(lz_d) - K_W'(lz_n);
  assign kp1 = LZ_W'(k + 8'sd1);
  assign num = (2*DATA_W-1)'(a_q) << FRAC_BITS;
  assign idx = cnt_q - LZ_W'(1);
  // Partial remainder stays below B, so one shifted-in bit needs only 65 bits
  assign r_sh = {r_q, num[idx]};
  assign ge = r_sh >= {1'b0, b_q};
  assign acc_nx = {acc_q, ge};
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    quo_d = quo_q;
    ovf_d = ovf_q;
    dbz_d = dbz_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d = dividend;
        b_d = divisor;
        state_d = NORM;
      end
      NORM: begin
        acc_d = '0;
        cnt_d = kp1;
        r_d = DATA_W'(num >> kp1);
        state_d = (b_q == '0 || a_q == '0 || k < 0 || k > 8'sd64) ? DONE : ITER;
        dbz_d = b_q == '0;
        ovf_d = b_q != '0 && a_q != '0 && k > 8'sd64;
        quo_d = (b_q == '0 || (a_q != '0 && k > 8'sd64)) ? SAT : '0;
      end
      ITER: begin
        r_d = ge ? DATA_W'(r_sh - {1'b0, b_q}) : r_sh[DATA_W-1:0];
        acc_d = acc_nx[DATA_W-1:0];
        cnt_d = idx;
        if (cnt_q == LZ_W'(1)) begin
          state_d = DONE;
          ovf_d = acc_nx[DATA_W];
          quo_d = acc_nx[DATA_W] ? SAT : acc_nx[DATA_W-1:0];
        end
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
        quo_d = '0;
        ovf_d = 1'b0;
        dbz_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      quo_q <= '0;
      ovf_q <= 1'b0;
      dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      quo_q <= quo_d;
      ovf_q <= ovf_d;
      dbz_q <= dbz_d;
    end
  assign in_ready = rst_n && state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign quotient = quo_q;
  assign overflow = ovf_q;
  assign div_by_zero = dbz_q;
endmodule

// File: doc/fxp_div_seq.md
# fxp_div_seq

Multi-cycle sequencer for unsigned fixed-point division. It accepts one operand pair over a valid/ready handshake and uses two instances of the 64-bit leading-zero detector to align the operands. It then runs only as many restoring-division iterations as the quotient can need, and returns a saturated quotient with status flags. It is the front end of the fixed-point divider and owns the only divide datapath; there is one operation in flight at a time.

## Interface
- FRAC_BITS, 32: fractional bits F of the operands and the quotient, all in unsigned Q(64-F).F. Legal range 0..63.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept operands. High only in IDLE.
- dividend  in  64  A.
- divisor  in  64  B.
- out_valid  out  1  result valid. High only in DONE.
- out_ready  in  1  consumer accepts the result.
- quotient  out  64  Q = floor(A·2^F / B), saturated.
- overflow  out  1  the true quotient is ≥ 2^64; Q = all ones.
- div_by_zero  out  1  B == 0; Q = all ones.

## Operation
- **States:** IDLE → NORM → (ITER →) DONE → IDLE.
- **IDLE:** in_ready = 1. On in_valid & in_ready, register A and B and go to NORM.
- **NORM (one cycle):**
  - Register lz_n = lzd(A) and lz_d = lzd(B).
  - Compute k = F + lz_d − lz_n as a signed 8-bit value; the range is −63..126.
  - Decide the path:
    - B == 0 → DONE with div_by_zero = 1 and Q = all ones.
    - A == 0 or k < 0 → DONE with Q = 0.
    - k ≥ 65 → DONE with overflow = 1 and Q = all ones.
    - Otherwise → ITER with an iteration counter of k+1.
- **ITER:** restoring division over quotient bit positions k down to 0, one bit per cycle.
  - The numerator is N = A·2^F, 127 bits wide.
  - The partial remainder R is 65 bits, initialized to N >> (k+1). This is always < B.
  - Each cycle: R' = (R<<1) | N[i]; if R' ≥ B, then R' −= B and the quotient bit is 1.
  - Quotient bits accumulate into a 65-bit register.
  - When the counter reaches 0, go to DONE. Set overflow = 1 if accumulator bit 64 is set, in which case Q = all ones; otherwise Q = accumulator[63:0].
- **DONE:** out_valid = 1. quotient and both flags are held stable until out_ready. On out_valid & out_ready, go to IDLE.
- The remainder is not exported.

## Timing
- **Reset:** all outputs are 0 (in_ready = 0 while rst_n is low; it is 1 from the first IDLE cycle), state = IDLE, and all internal registers are 0. Reset asserted mid-operation abandons the operation with no result. The first accept after deassertion is possible in the first clock cycle.
- **Latency:** count from the accepting edge t. NORM occupies cycle t+1.
  - Shortcut paths (divide-by-zero, zero, k < 0, k ≥ 65): out_valid rises in cycle t+2.
  - Iterative path: out_valid rises in cycle t+2+(k+1). The worst case is k = 64, giving t+67.
- **Throughput:** there is no overlap. in_ready is 0 from NORM through the DONE handshake cycle inclusive. The next accept is possible in the cycle after the out handshake.
- **Back-pressure:** out_valid stays high and the outputs stay frozen for any number of cycles with out_ready = 0.
- **Input hold:** in_valid with in_ready = 0 has no effect. The source must hold its operands; the block samples only on the handshake.
- **Flags:** overflow and div_by_zero are mutually exclusive and are valid only while out_valid = 1. They are 0 otherwise.

## Structure
- **Shared package fxp_div_pkg** holds:
  - the state enum {IDLE, NORM, ITER, DONE};
  - DATA_W = 64, LZ_W = 7 and K_W = 8;
  - the saturation constant (all ones).
- **Sub-modules:**
  - Two instances of the existing LZD_64bit, one on registered A and one on registered B, feeding NORM.
  - The restoring step (compare, subtract, shift) stays inline. There is no separate module.

## Test plan
- **Normal divide:** F = 32, A = 0x0000_0006_0000_0000 (6.0), B = 0x0000_0002_0000_0000 (2.0) → k = 33, Q = 0x0000_0003_0000_0000, flags 0, out_valid at t+36.
- **Divide by zero:** A = 0x1234, B = 0 → Q = 0xFFFF_FFFF_FFFF_FFFF, div_by_zero = 1, overflow = 0, out_valid at t+2.
- **Small quotient:**
  - F = 32, A = 1, B = 0xFFFF_FFFF_FFFF_FFFF → k = −31, Q = 0, flags 0 at t+2.
  - A = 0, B = 5 → Q = 0 at t+2.
- **Overflow:**
  - F = 32, A = all ones, B = 1 → k = 95, overflow = 1, Q = all ones at t+2.
  - F = 0, A = all ones, B = 1 → k = 63, Q = all ones, overflow = 0, out_valid at t+66.
- **Back-pressure:** hold out_ready = 0 for 5 cycles after out_valid → quotient and flags are unchanged and in_ready = 0 throughout. A second in_valid is accepted only in the cycle after the out handshake.
- **Reset mid-operation:** assert rst_n = 0 during ITER of a k = 40 divide → all outputs 0 immediately. After release, in_ready = 1 and a fresh divide returns the correct result.
